row_plotter: RTL and testbench

- Downstream stage of the Game of Life grid controller; renders one 40-cell grid row per transaction to the 160x120 VGA adapter.
- Receives a row index and 40-bit row word through a valid/ready handshake.
- Expands each cell into a CELL_PX x CELL_PX pixel block and drives one pixel per clock (x, y, colour, plot).
- Flags completion of the last row of a frame.

---
 rtl/gol_pkg.sv | 22 ++
 rtl/scan_counter.sv | 31 +++
 rtl/row_plotter.sv | 121 ++++++++++++
 tb/tb_row_plotter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared constants and state encoding for the Game of Life display path.
package gol_pkg;

   localparam int unsigned COLS      = 40;
   localparam int unsigned ROWS      = 30;
   localparam int unsigned CELL_PX   = 4;
   localparam int unsigned X_W       = 8;
   localparam int unsigned Y_W       = 7;
   localparam int unsigned ROW_W     = 5;
   localparam int unsigned COL_W     = $clog2(COLS);
   localparam int unsigned PX_SIDE_W = $clog2(CELL_PX);
   localparam int unsigned PX_W      = 2 * PX_SIDE_W;

   localparam logic [2:0] ALIVE_COLOUR = 3'b111;
   localparam logic [2:0] DEAD_COLOUR  = 3'b000;

   typedef enum logic {
      StIdle = 1'b0,
      StPlot = 1'b1
   } state_e;

endpackage

// File: rtl/scan_counter.sv
// Wrap-around counter with enable, synchronous clear and terminal-count flag.
module scan_counter #(
   parameter int unsigned Modulo = 16,
   parameter int unsigned Width  = $clog2(Modulo)
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o,
   output logic             tc_o
);

   logic [Width-1:0] count_q, count_d;

   assign tc_o    = (count_q == Width'(Modulo - 1));
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = tc_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      count_q <= count_d;
   end

endmodule

// File: rtl/row_plotter.sv
// Expands one 40-cell grid row into CELL_PX x CELL_PX pixel blocks, one pixel per clock.
module row_plotter
   import gol_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              row_valid,
   output logic              row_ready,
   input  logic [ROW_W-1:0]  row_idx,
   input  logic [COLS-1:0]   row_data,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [2:0]        colour,
   output logic              plot,
   output logic              busy,
   output logic              frame_done
);

   state_e             state_q, state_d;
   logic               row_ready_q, plot_q, frame_done_q;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [2:0]         colour_q, colour_d;
   logic [ROW_W-1:0]   row_q;
   logic [COLS-1:0]    data_q;
   logic               accept, start, last;
   logic [PX_W-1:0]    px_cnt;
   logic [COL_W-1:0]   col_cnt;
   logic               px_tc, col_tc;

   scan_counter #(
      .Modulo (CELL_PX * CELL_PX),
      .Width  (PX_W)
   ) u_px_cnt (
      .clk_i   (clk),
      .clear_i (reset | start),
      .en_i    (state_q == StPlot),
      .count_o (px_cnt),
      .tc_o    (px_tc)
   );

   scan_counter #(
      .Modulo (COLS),
      .Width  (COL_W)
   ) u_col_cnt (
      .clk_i   (clk),
      .clear_i (reset | start),
      .en_i    ((state_q == StPlot) & px_tc),
      .count_o (col_cnt),
      .tc_o    (col_tc)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      start   = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (row_valid && row_ready_q) begin
               accept = 1'b1;
               // Out-of-range rows are consumed but never drawn.
               if (row_idx < ROW_W'(ROWS)) begin
                  start   = 1'b1;
                  state_d = StPlot;
               end
            end
         end
         StPlot: begin
            if (px_tc && col_tc) begin
               last    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      x_d      = (X_W'(col_cnt) << PX_SIDE_W) | X_W'(px_cnt[PX_SIDE_W-1:0]);
      y_d      = (Y_W'(row_q) << PX_SIDE_W) | Y_W'(px_cnt[PX_W-1:PX_SIDE_W]);
      colour_d = data_q[COL_W'(COLS - 1) - col_cnt] ? ALIVE_COLOUR : DEAD_COLOUR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         row_ready_q  <= 1'b0;
         plot_q       <= 1'b0;
         frame_done_q <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         colour_q     <= '0;
         row_q        <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         row_ready_q  <= (state_d == StIdle);
         plot_q       <= (state_q == StPlot);
         frame_done_q <= last && (row_q == ROW_W'(ROWS - 1));
         if (state_q == StPlot) begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
         end
         if (accept) begin
            row_q  <= row_idx;
            data_q <= row_data;
         end
      end
   end

   assign row_ready  = row_ready_q;
   assign busy       = (state_q == StPlot);
   assign plot       = plot_q;
   assign frame_done = frame_done_q;
   assign x          = x_q;
   assign y          = y_q;
   assign colour     = colour_q;

endmodule

// File: tb/tb_row_plotter.sv
// Self-checking bench for row_plotter: vector table plus scoreboard of expected pixels.
module tb_row_plotter;

   logic        clk = 1'b0;
   logic        reset;
   logic        row_valid;
   logic        row_ready;
   logic [4:0]  row_idx;
   logic [39:0] row_data;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        busy;
   logic        frame_done;

   always #5 clk = ~clk;

   row_plotter dut (
      .clk        (clk),
      .reset      (reset),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .row_idx    (row_idx),
      .row_data   (row_data),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .busy       (busy),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
      bit         last29;
   } pix_t;

   typedef struct {
      logic [4:0]  idx;
      logic [39:0] data;
      int          plots;
      int          fds;
   } vec_t;

   pix_t   exp_q[$];
   vec_t   vecs[6];
   int     n_checks = 0;
   int     n_fail = 0;
   int     plot_cnt = 0;
   int     fd_cnt = 0;
   int     row_pix = 0;
   int     last_gap = -1;
   longint cyc = 0;
   longint last_plot_cyc = -1;
   bit     prev_plot = 1'b0;
   bit     mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Expected pixel stream for one row, derived from the x/y/colour formulas.
   task automatic push_row(input logic [4:0] idx, input logic [39:0] data);
      pix_t p;
      if (idx < 5'd30) begin
         for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < 16; k++) begin
               p.x      = 8'(c * 4 + (k % 4));
               p.y      = 7'(int'(idx) * 4 + (k / 4));
               p.colour = data[39 - c] ? 3'b111 : 3'b000;
               p.last29 = (idx == 5'd29) && (c == 39) && (k == 15);
               exp_q.push_back(p);
            end
         end
      end
      row_pix = 0;
   endtask

   task automatic wait_ready(input bit toggle);
      int t = 0;
      while (row_ready !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
         if (toggle) begin
            row_idx  = ~row_idx;
            row_data = ~row_data;
         end
      end
      if (t >= 2000) check("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_row(input logic [4:0] idx, input logic [39:0] data);
      row_valid = 1'b1;
      row_idx   = idx;
      row_data  = data;
      wait_ready(1'b0);
      push_row(idx, data);
      @(negedge clk);
      row_valid = 1'b0;
   endtask

   initial begin : monitor
      pix_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (mon_en) begin
            if (plot === 1'b1) begin
               if (!prev_plot && last_plot_cyc >= 0) last_gap = int'(cyc - last_plot_cyc - 1);
               last_plot_cyc = cyc;
               plot_cnt++;
               row_pix++;
               if (exp_q.size() == 0) begin
                  check("unexpected_plot", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("pixel_xyc", {46'd0, x, y, colour}, {46'd0, e.x, e.y, e.colour});
                  if (frame_done === 1'b1 || e.last29)
                     check("frame_done_pulse", {63'd0, frame_done}, {63'd0, e.last29});
               end
            end else if (frame_done !== 1'b0) begin
               check("stray_frame_done", {63'd0, frame_done}, 64'd0);
            end
            if (frame_done === 1'b1) fd_cnt++;
            prev_plot = (plot === 1'b1);
         end
      end
   end

   initial begin
      int p0;
      int f0;
      int t;
      reset     = 1'b1;
      row_valid = 1'b0;
      row_idx   = '0;
      row_data  = '0;
      vecs[0] = '{idx: 5'd0,  data: 40'h80_0000_0000, plots: 640, fds: 0};
      vecs[1] = '{idx: 5'd29, data: {40{1'b1}},       plots: 640, fds: 1};
      vecs[2] = '{idx: 5'd30, data: {40{1'b1}},       plots: 0,   fds: 0};
      vecs[3] = '{idx: 5'd12, data: 40'h01_2345_6789, plots: 640, fds: 0};
      vecs[4] = '{idx: 5'd31, data: 40'hFF_0000_00FF, plots: 0,   fds: 0};
      vecs[5] = '{idx: 5'd29, data: 40'h00_0000_0001, plots: 640, fds: 1};

      repeat (2) @(negedge clk);
      check("reset_row_ready", {63'd0, row_ready}, 64'd0);
      check("reset_plot", {63'd0, plot}, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_frame_done", {63'd0, frame_done}, 64'd0);
      check("reset_xyc", {46'd0, x, y, colour}, 64'd0);
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {63'd0, row_ready}, 64'd1);

      for (int i = 0; i < 6; i++) begin
         p0 = plot_cnt;
         f0 = fd_cnt;
         send_row(vecs[i].idx, vecs[i].data);
         check("busy_after_accept", {63'd0, busy}, (vecs[i].plots > 0) ? 64'd1 : 64'd0);
         check("ready_after_accept", {63'd0, row_ready}, (vecs[i].plots > 0) ? 64'd0 : 64'd1);
         wait_ready(1'b0);
         check("plot_count_at_ready", 64'(plot_cnt - p0), 64'(vecs[i].plots));
         repeat (3) @(negedge clk);
         check("plot_count", 64'(plot_cnt - p0), 64'(vecs[i].plots));
         check("frame_done_count", 64'(fd_cnt - f0), 64'(vecs[i].fds));
         check("queue_drained", 64'(exp_q.size()), 64'd0);
      end

      // Back-to-back rows with row_valid held high throughout.
      p0 = plot_cnt;
      row_valid = 1'b1;
      row_idx   = 5'd5;
      row_data  = 40'hF0_F0F0_F00F;
      wait_ready(1'b0);
      push_row(5'd5, 40'hF0_F0F0_F00F);
      @(negedge clk);
      row_idx  = 5'd6;
      row_data = 40'h12_3456_789A;
      wait_ready(1'b0);
      push_row(5'd6, 40'h12_3456_789A);
      @(negedge clk);
      row_valid = 1'b0;
      wait_ready(1'b0);
      repeat (3) @(negedge clk);
      check("b2b_plot_count", 64'(plot_cnt - p0), 64'd1280);
      check("b2b_gap", 64'(last_gap), 64'd1);
      check("b2b_queue_drained", 64'(exp_q.size()), 64'd0);

      // Inputs toggling every cycle while a row is being drawn.
      p0 = plot_cnt;
      send_row(5'd10, 40'hAA_AAAA_AAAA);
      wait_ready(1'b1);
      repeat (3) @(negedge clk);
      check("toggle_plot_count", 64'(plot_cnt - p0), 64'd640);
      check("toggle_queue_drained", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of the last row of a frame.
      send_row(5'd29, {40{1'b1}});
      t = 0;
      while (row_pix < 300 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("pixel300_timeout", 64'd0, 64'd1);
      f0 = fd_cnt;
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midreset_plot", {63'd0, plot}, 64'd0);
      check("midreset_busy", {63'd0, busy}, 64'd0);
      check("midreset_ready_low", {63'd0, row_ready}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("midreset_ready_high", {63'd0, row_ready}, 64'd1);
      repeat (3) @(negedge clk);
      check("midreset_no_frame_done", 64'(fd_cnt - f0), 64'd0);
      p0 = plot_cnt;
      send_row(5'd3, 40'h5A_C3F0_0F3C);
      wait_ready(1'b0);
      repeat (3) @(negedge clk);
      check("post_reset_plot_count", 64'(plot_cnt - p0), 64'd640);
      check("post_reset_queue_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
